uart_rx_frame: RTL



---
 rtl/uart_rx_frame.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: parametrised UART receiver with sent/recieved handshake and error code.
//
// Ports:
//   clk       system clock, all logic on the rising edge
//   reset     synchronous active-high reset
//   rx        asynchronous serial line, idle high
//   recieved  consumer acknowledge; clears sent
//   data      last received payload (DATA_BITS wide, first line bit in bit 0)
//   sent      payload valid, held until acknowledged
//   error     0 ok, 1 parity, 2 framing (stop = 0), 3 overrun
//
// Optional build macro: UART_RX_MAJORITY_EN
//   Defined: each bit is a 2-of-3 vote of rx_s at mid-1, mid and mid+1, decided at mid+1
//   (one extra clock of latency). Undefined: a single sample at mid-bit.
module uart_rx_frame #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_MODE  = 1,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 recieved,
    output logic [DATA_BITS-1:0] data,
    output logic                 sent,
    output logic [3:0]           error
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
`ifdef UART_RX_MAJORITY_EN
    localparam int unsigned VOTE_DELAY = 1;
`else
    localparam int unsigned VOTE_DELAY = 0;
`endif
    // Start bit is decided half a bit in; every later decision lands one full bit after it.
    localparam logic [CW-1:0] START_DEC = CW'(CLKS_PER_BIT / 2 - 1 + VOTE_DELAY);
    localparam logic [CW-1:0] BIT_DEC   = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic          ODD       = 1'(PARITY_MODE == 2);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StComplete,
        StWaitHigh
    } state_e;

    state_e               state_q;
    logic [1:0]           sync_q;
    logic [CW-1:0]        cnt_q;
    logic [3:0]           idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_err_q;
    logic                 stop_err_q;
`ifdef UART_RX_MAJORITY_EN
    logic [1:0]           hist_q;   // rx_s one and two clocks ago
`endif

    logic rx_s;
    logic bit_val;
    logic par_exp;
    logic frame_err;

    always_comb begin
        rx_s = sync_q[1];
`ifdef UART_RX_MAJORITY_EN
        bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
        bit_val = rx_s;
`endif
        par_exp   = (^shift_q) ^ ODD;
        frame_err = stop_err_q | ~bit_val;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            sync_q     <= 2'b11;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            par_err_q  <= 1'b0;
            stop_err_q <= 1'b0;
            data       <= '0;
            sent       <= 1'b0;
            error      <= 4'd0;
`ifdef UART_RX_MAJORITY_EN
            hist_q     <= 2'b11;
`endif
        end else begin
            sync_q <= {sync_q[0], rx};
`ifdef UART_RX_MAJORITY_EN
            hist_q <= {hist_q[0], rx_s};
`endif
            // Ack first; a frame finishing in the same cycle re-asserts sent below.
            if (sent && recieved) begin
                sent <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (!rx_s) begin
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (cnt_q == START_DEC) begin
                        cnt_q <= '0;
                        idx_q <= '0;
                        state_q <= bit_val ? StIdle : StData;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (cnt_q == BIT_DEC) begin
                        cnt_q   <= '0;
                        shift_q <= {bit_val, shift_q[DATA_BITS-1:1]};
                        idx_q   <= idx_q + 1'b1;
                        if (idx_q == LAST_DATA) begin
                            idx_q      <= '0;
                            par_err_q  <= 1'b0;
                            stop_err_q <= 1'b0;
                            state_q    <= (PARITY_MODE != 0) ? StParity : StStop;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StParity: begin
                    if (cnt_q == BIT_DEC) begin
                        cnt_q     <= '0;
                        par_err_q <= (bit_val != par_exp);
                        state_q   <= StStop;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    if (cnt_q == BIT_DEC) begin
                        cnt_q <= '0;
                        if (idx_q == LAST_STOP) begin
                            // Outputs load on this edge so they are valid the edge after
                            // the final stop sample; COMPLETE then only watches the line.
                            state_q <= StComplete;
                            if (par_err_q) begin
                                data  <= shift_q;
                                error <= 4'd1;
                            end else if (frame_err) begin
                                data  <= shift_q;
                                error <= 4'd2;
                            end else if (!sent || recieved) begin
                                data  <= shift_q;
                                error <= 4'd0;
                                sent  <= 1'b1;
                            end else begin
                                error <= 4'd3;
                            end
                        end else begin
                            stop_err_q <= stop_err_q | ~bit_val;
                            idx_q      <= idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StComplete: begin
                    // A line still low here is a break; wait for idle before re-arming.
                    state_q <= rx_s ? StIdle : StWaitHigh;
                end
                StWaitHigh: begin
                    if (rx_s) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
